// File: rtl/anim_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the animation frame sequencer.
// The picture window is centred on the 640x480 active area.
package anim_pkg;

    localparam int H_VALID   = 640;
    localparam int V_VALID   = 480;
    localparam int PIC_W     = 500;
    localparam int PIC_H     = 312;
    localparam int PIC_SIZE  = PIC_W * PIC_H;
    localparam int FRAME_CNT = 4;
    localparam int ADDR_W    = 20;
    localparam int IDX_W     = $clog2(FRAME_CNT);

    localparam int X0 = (H_VALID - PIC_W) / 2;
    localparam int Y0 = (V_VALID - PIC_H) / 2;

    // The window opens one column early so ROM data lines up with pixel X0.
    localparam logic [9:0] WIN_X_LO = 10'(X0 - 1);
    localparam logic [9:0] WIN_X_HI = 10'(X0 - 1 + PIC_W);
    localparam logic [9:0] WIN_Y_LO = 10'(Y0);
    localparam logic [9:0] WIN_Y_HI = 10'(Y0 + PIC_H);
    localparam logic [9:0] LAST_X   = 10'(H_VALID - 1);
    localparam logic [9:0] LAST_Y   = 10'(V_VALID - 1);

    localparam logic [ADDR_W-1:0] PIC_SIZE_A = ADDR_W'(PIC_SIZE);
    localparam logic [ADDR_W-1:0] PIC_LAST_A = ADDR_W'(PIC_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'((FRAME_CNT - 1) * PIC_SIZE);

    typedef enum logic [1:0] {
        PAUSE,
        PLAY,
        STEP_PEND
    } state_e;

    function automatic logic [3:0] hold_limit(input logic [3:0] sel);
        return (sel == 4'd0) ? 4'd1 : sel;
    endfunction

endpackage

// File: rtl/anim_sequencer_if.sv
// Pixel-counter, control and ROM-side signals of the frame sequencer.
// The slave modport is the sequencer; the master modport drives it.
interface anim_sequencer_if;
    import anim_pkg::*;

    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              play;
    logic              step;
    logic              dir;
    logic [3:0]        hold_sel;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic              pic_valid;
    logic [IDX_W-1:0]  frame_idx;
    logic              frame_start;

    modport slave (
        input  pix_x, pix_y, play, step, dir, hold_sel,
        output rom_en, rom_addr, pic_valid, frame_idx, frame_start
    );

    modport master (
        output pix_x, pix_y, play, step, dir, hold_sel,
        input  rom_en, rom_addr, pic_valid, frame_idx, frame_start
    );

endinterface

// File: rtl/anim_sequencer_window.sv
// Picture window decode, ROM-latency-aligned valid flag and frame tick detection.
// The tick fires once per entry into the last pixel, even if the counters stall there.
module anim_window
    import anim_pkg::*;
(
    input  logic       vga_clk,
    input  logic       rst,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    output logic       rom_en_o,
    output logic       pic_valid_o,
    output logic       tick_o,
    output logic       frame_start_o
);

    logic cond;
    logic cond_q;
    logic pic_valid_q;
    logic frame_start_q;

    assign rom_en_o = (pix_x_i >= WIN_X_LO) && (pix_x_i < WIN_X_HI) &&
                      (pix_y_i >= WIN_Y_LO) && (pix_y_i < WIN_Y_HI);
    assign cond     = (pix_x_i == LAST_X) && (pix_y_i == LAST_Y);
    assign tick_o   = cond && !cond_q;

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            cond_q        <= 1'b0;
            pic_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cond_q        <= cond;
            pic_valid_q   <= rom_en_o;
            frame_start_q <= tick_o;
        end
    end

    assign pic_valid_o   = pic_valid_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/anim_sequencer.sv
// Frame sequencer top: play/pause/step FSM, hold counter, frame base and ROM address.
// Frame index, base and address only ever change together on a frame tick.
module anim_sequencer
    import anim_pkg::*;
(
    input  logic             vga_clk,
    input  logic             rst,
    anim_sequencer_if.slave  bus_if
);

    state_e            state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rom_en;
    logic              pic_valid;
    logic              frame_start;
    logic              tick;
    logic              advance;

    anim_window u_window (
        .vga_clk       (vga_clk),
        .rst           (rst),
        .pix_x_i       (bus_if.pix_x),
        .pix_y_i       (bus_if.pix_y),
        .rom_en_o      (rom_en),
        .pic_valid_o   (pic_valid),
        .tick_o        (tick),
        .frame_start_o (frame_start)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        advance = 1'b0;
        case (state_q)
            PAUSE: begin
                if (bus_if.play) begin
                    state_d = PLAY;
                    hold_d  = 4'd0;
                end else if (bus_if.step) begin
                    state_d = STEP_PEND;
                end
            end
            PLAY: begin
                if (!bus_if.play) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    // >= also recovers if hold_sel is lowered below the running count.
                    if (({1'b0, hold_q} + 5'd1) >= {1'b0, hold_limit(bus_if.hold_sel)}) begin
                        advance = 1'b1;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d  = hold_q + 4'd1;
                    end
                end
            end
            STEP_PEND: begin
                if (bus_if.play) begin
                    state_d = PLAY;
                    hold_d  = 4'd0;
                end else if (tick) begin
                    advance = 1'b1;
                    state_d = PAUSE;
                end
            end
            default: state_d = PAUSE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        base_d = base_q;
        addr_d = addr_q;
        if (advance) begin
            if (!bus_if.dir) begin
                if (idx_q == IDX_W'(FRAME_CNT - 1)) begin
                    idx_d  = '0;
                    base_d = '0;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    base_d = base_q + PIC_SIZE_A;
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d  = IDX_W'(FRAME_CNT - 1);
                    base_d = LAST_BASE;
                end else begin
                    idx_d  = idx_q - IDX_W'(1);
                    base_d = base_q - PIC_SIZE_A;
                end
            end
        end
        // The tick lies outside the window, so reload and increment never compete.
        if (tick) begin
            addr_d = base_d;
        end else if (rom_en && (addr_q != base_q + PIC_LAST_A)) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            state_q <= PAUSE;
            hold_q  <= 4'd0;
            idx_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
        end
    end

    assign bus_if.rom_en      = rom_en;
    assign bus_if.rom_addr    = addr_q;
    assign bus_if.pic_valid   = pic_valid;
    assign bus_if.frame_idx   = idx_q;
    assign bus_if.frame_start = frame_start;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed self-checking bench for anim_sequencer: window, play/reverse, step,
// stalled-counter tick and asynchronous reset, with hand-computed expectations.
module tb_anim_sequencer;
    import anim_pkg::*;

    logic vga_clk;
    logic rst;
    int   checks;
    int   fails;
    logic fs_seen;

    anim_sequencer_if bus_if ();

    anim_sequencer dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .bus_if  (bus_if.slave)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic cycle();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        bus_if.pix_x = 10'(x);
        bus_if.pix_y = 10'(y);
    endtask

    // One frame tick at the last pixel; fs_seen records the frame_start pulse.
    task automatic frame_tick();
        set_pix(639, 479);
        cycle();
        fs_seen = bus_if.frame_start;
        set_pix(0, 0);
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_pix(0, 0);
        bus_if.play = 1'b0;
        bus_if.step = 1'b0;
        bus_if.dir = 1'b0;
        bus_if.hold_sel = 4'd0;
        repeat (3) cycle();
        checks++;
        if (bus_if.rom_addr !== 20'd0) begin fails++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", bus_if.rom_addr); end
        checks++;
        if (bus_if.pic_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_pic_valid: got %b expected 0", bus_if.pic_valid); end
        checks++;
        if (bus_if.frame_idx !== 2'd0) begin fails++; $display("[TB] FAIL reset_frame_idx: got %0d expected 0", bus_if.frame_idx); end
        checks++;
        if (bus_if.frame_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_start: got %b expected 0", bus_if.frame_start); end
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_window();
        set_pix(68, 84);
        #1;
        checks++;
        if (bus_if.rom_en !== 1'b0) begin fails++; $display("[TB] FAIL win_x68: got %b expected 0", bus_if.rom_en); end
        cycle();
        set_pix(69, 84);
        #1;
        checks++;
        if (bus_if.rom_en !== 1'b1) begin fails++; $display("[TB] FAIL win_x69: got %b expected 1", bus_if.rom_en); end
        checks++;
        if (bus_if.rom_addr !== 20'd0) begin fails++; $display("[TB] FAIL win_first_addr: got %0d expected 0", bus_if.rom_addr); end
        checks++;
        if (bus_if.pic_valid !== 1'b0) begin fails++; $display("[TB] FAIL win_valid_x69: got %b expected 0", bus_if.pic_valid); end
        cycle();
        set_pix(70, 84);
        checks++;
        if (bus_if.pic_valid !== 1'b1) begin fails++; $display("[TB] FAIL win_valid_x70: got %b expected 1", bus_if.pic_valid); end
        checks++;
        if (bus_if.rom_addr !== 20'd1) begin fails++; $display("[TB] FAIL win_addr_x70: got %0d expected 1", bus_if.rom_addr); end
        for (int x = 70; x <= 78; x++) begin
            set_pix(x, 84);
            cycle();
        end
        checks++;
        if (bus_if.rom_addr !== 20'd10) begin fails++; $display("[TB] FAIL win_addr_run: got %0d expected 10", bus_if.rom_addr); end
        set_pix(568, 84);
        #1;
        checks++;
        if (bus_if.rom_en !== 1'b1) begin fails++; $display("[TB] FAIL win_x568: got %b expected 1", bus_if.rom_en); end
        set_pix(569, 84);
        #1;
        checks++;
        if (bus_if.rom_en !== 1'b0) begin fails++; $display("[TB] FAIL win_x569: got %b expected 0", bus_if.rom_en); end
        set_pix(100, 83);
        #1;
        checks++;
        if (bus_if.rom_en !== 1'b0) begin fails++; $display("[TB] FAIL win_y83: got %b expected 0", bus_if.rom_en); end
        set_pix(100, 395);
        #1;
        checks++;
        if (bus_if.rom_en !== 1'b1) begin fails++; $display("[TB] FAIL win_y395: got %b expected 1", bus_if.rom_en); end
        set_pix(100, 396);
        #1;
        checks++;
        if (bus_if.rom_en !== 1'b0) begin fails++; $display("[TB] FAIL win_y396: got %b expected 0", bus_if.rom_en); end
        set_pix(0, 0);
        cycle();
        frame_tick();
        checks++;
        if (bus_if.frame_idx !== 2'd0) begin fails++; $display("[TB] FAIL pause_tick_idx: got %0d expected 0", bus_if.frame_idx); end
        checks++;
        if (bus_if.rom_addr !== 20'd0) begin fails++; $display("[TB] FAIL pause_tick_reload: got %0d expected 0", bus_if.rom_addr); end
        checks++;
        if (fs_seen !== 1'b1) begin fails++; $display("[TB] FAIL pause_tick_fs: got %b expected 1", fs_seen); end
    endtask

    task automatic test_play_forward();
        logic [1:0]  exp_idx [10];
        logic [19:0] exp_addr [10];
        exp_idx  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        exp_addr = '{20'd0, 20'd0, 20'd156000, 20'd156000, 20'd312000, 20'd312000,
                     20'd468000, 20'd468000, 20'd0, 20'd0};
        bus_if.play = 1'b1;
        bus_if.hold_sel = 4'd2;
        bus_if.dir = 1'b0;
        cycle();
        for (int k = 1; k <= 9; k++) begin
            frame_tick();
            checks++;
            if (bus_if.frame_idx !== exp_idx[k]) begin fails++; $display("[TB] FAIL fwd_idx_tick%0d: got %0d expected %0d", k, bus_if.frame_idx, exp_idx[k]); end
            checks++;
            if (bus_if.rom_addr !== exp_addr[k]) begin fails++; $display("[TB] FAIL fwd_addr_tick%0d: got %0d expected %0d", k, bus_if.rom_addr, exp_addr[k]); end
        end
    endtask

    task automatic test_play_reverse();
        logic [1:0]  exp_idx [3];
        logic [19:0] exp_addr [3];
        exp_idx  = '{2'd3, 2'd2, 2'd1};
        exp_addr = '{20'd468000, 20'd312000, 20'd156000};
        bus_if.play = 1'b0;
        cycle();
        bus_if.dir = 1'b1;
        bus_if.hold_sel = 4'd0;
        bus_if.play = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            frame_tick();
            checks++;
            if (bus_if.frame_idx !== exp_idx[k]) begin fails++; $display("[TB] FAIL rev_idx_%0d: got %0d expected %0d", k, bus_if.frame_idx, exp_idx[k]); end
            checks++;
            if (bus_if.rom_addr !== exp_addr[k]) begin fails++; $display("[TB] FAIL rev_addr_%0d: got %0d expected %0d", k, bus_if.rom_addr, exp_addr[k]); end
        end
        bus_if.play = 1'b0;
        cycle();
    endtask

    task automatic test_step();
        bus_if.dir = 1'b0;
        set_pix(600, 200);
        bus_if.step = 1'b1;
        cycle();
        bus_if.step = 1'b0;
        repeat (4) cycle();
        checks++;
        if (bus_if.frame_idx !== 2'd1) begin fails++; $display("[TB] FAIL step_midframe_idx: got %0d expected 1", bus_if.frame_idx); end
        frame_tick();
        checks++;
        if (bus_if.frame_idx !== 2'd2) begin fails++; $display("[TB] FAIL step_tick_idx: got %0d expected 2", bus_if.frame_idx); end
        checks++;
        if (bus_if.rom_addr !== 20'd312000) begin fails++; $display("[TB] FAIL step_tick_addr: got %0d expected 312000", bus_if.rom_addr); end
        frame_tick();
        checks++;
        if (bus_if.frame_idx !== 2'd2) begin fails++; $display("[TB] FAIL step_once_idx: got %0d expected 2", bus_if.frame_idx); end
        bus_if.play = 1'b1;
        bus_if.hold_sel = 4'd3;
        cycle();
        bus_if.step = 1'b1;
        cycle();
        bus_if.step = 1'b0;
        cycle();
        frame_tick();
        checks++;
        if (bus_if.frame_idx !== 2'd2) begin fails++; $display("[TB] FAIL step_in_play_idx: got %0d expected 2", bus_if.frame_idx); end
        bus_if.play = 1'b0;
        cycle();
        frame_tick();
        checks++;
        if (bus_if.frame_idx !== 2'd2) begin fails++; $display("[TB] FAIL step_dropped_idx: got %0d expected 2", bus_if.frame_idx); end
    endtask

    task automatic test_stalled_corner();
        int pulses;
        pulses = 0;
        set_pix(639, 479);
        repeat (5) begin
            cycle();
            if (bus_if.frame_start === 1'b1) pulses++;
        end
        set_pix(0, 0);
        cycle();
        if (bus_if.frame_start === 1'b1) pulses++;
        checks++;
        if (pulses !== 1) begin fails++; $display("[TB] FAIL stall_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_reset_midframe();
        bus_if.dir = 1'b1;
        bus_if.step = 1'b1;
        cycle();
        bus_if.step = 1'b0;
        cycle();
        frame_tick();
        checks++;
        if (bus_if.rom_addr !== 20'd156000) begin fails++; $display("[TB] FAIL rstmid_base: got %0d expected 156000", bus_if.rom_addr); end
        set_pix(100, 100);
        repeat (44000) cycle();
        checks++;
        if (bus_if.rom_addr !== 20'd200000) begin fails++; $display("[TB] FAIL rstmid_addr_pre: got %0d expected 200000", bus_if.rom_addr); end
        checks++;
        if (bus_if.frame_idx !== 2'd1) begin fails++; $display("[TB] FAIL rstmid_idx_pre: got %0d expected 1", bus_if.frame_idx); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.rom_addr !== 20'd0) begin fails++; $display("[TB] FAIL rstmid_addr: got %0d expected 0", bus_if.rom_addr); end
        checks++;
        if (bus_if.frame_idx !== 2'd0) begin fails++; $display("[TB] FAIL rstmid_idx: got %0d expected 0", bus_if.frame_idx); end
        checks++;
        if (bus_if.pic_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid: got %b expected 0", bus_if.pic_valid); end
        cycle();
        set_pix(0, 0);
        rst = 1'b1;
        cycle();
        frame_tick();
        checks++;
        if (bus_if.frame_idx !== 2'd0) begin fails++; $display("[TB] FAIL rstmid_paused_idx: got %0d expected 0", bus_if.frame_idx); end
        checks++;
        if (fs_seen !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_fs: got %b expected 1", fs_seen); end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        fs_seen = 1'b0;
        test_reset();
        test_window();
        test_play_forward();
        test_play_reverse();
        test_step();
        test_stalled_corner();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Frame sequencer for the animation projector's picture path. It sits between the VGA pixel counters and the single-port picture ROM, which holds `FRAME_CNT` consecutive 500x312 RGB565 frames. It generates the ROM enable and address for the centred picture window. It also steps the displayed frame at frame boundaries under play, pause, single-step and direction control.

## Interface
- `H_VALID`, 640: active pixels per line.
- `V_VALID`, 480: active lines per frame.
- `PIC_W`, 500: picture width in pixels.
- `PIC_H`, 312: picture height in lines.
- `FRAME_CNT`, 4: number of frames stored in the ROM, contiguous from address 0.
- `ADDR_W`, 20: ROM address width; must satisfy FRAME_CNT*PIC_W*PIC_H ≤ 2^ADDR_W.
- `vga_clk`  in  1  pixel clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pix_x`  in  10  current pixel column.
- `pix_y`  in  10  current pixel row.
- `play`  in  1  level; 1 = run the animation, 0 = pause.
- `step`  in  1  single-cycle pulse; advances one frame while paused.
- `dir`  in  1  0 = forward, 1 = reverse; sampled at advance.
- `hold_sel`  in  4  frame ticks per image; 0 is treated as 1; sampled at each frame tick.
- `rom_en`  out  1  ROM read enable (combinational window decode).
- `rom_addr`  out  ADDR_W  ROM read address (registered).
- `pic_valid`  out  1  ROM data valid this cycle; selects picture vs background.
- `frame_idx`  out  log2(FRAME_CNT)  index of the frame being displayed.
- `frame_start`  out  1  one-cycle pulse on each frame tick.

## Operation
- Window constants: X0=(H_VALID-PIC_W)/2=70, Y0=(V_VALID-PIC_H)/2=84.
- `rom_en` = (X0-1 ≤ pix_x < X0-1+PIC_W) && (Y0 ≤ pix_y < Y0+PIC_H).
  - This gives x 69..568 and y 84..395.
  - The window is shifted one column early to absorb the one-cycle ROM latency.
- Frame tick:
  - `cond` = (pix_x==H_VALID-1 && pix_y==V_VALID-1).
  - tick = cond && !cond_d, so it fires exactly once even if the counters stall.
  - `frame_start` is the registered tick.
- Address:
  - `rom_addr` increments by 1 on every cycle with `rom_en`=1.
  - It saturates at base+PIC_SIZE-1, where PIC_SIZE=PIC_W*PIC_H=156000.
  - On a tick, `rom_addr` is loaded with the base of the next displayed frame, which may be unchanged.
- Base register:
  - base = frame_idx*PIC_SIZE, maintained by adding or subtracting PIC_SIZE with wrap.
  - No multiplier is used.
- FSM states:
  - PAUSE:
    - play=1 moves to PLAY.
    - A step pulse sets STEP_PEND.
  - PLAY:
    - play=0 moves to PAUSE.
    - step is ignored.
    - hold_cnt counts ticks. When hold_cnt+1 == max(hold_sel,1), the frame advances and hold_cnt is cleared.
  - STEP_PEND:
    - At the next tick, advance once and return to PAUSE.
    - play=1 moves to PLAY, the pending step is dropped, and hold_cnt is cleared.
- Advance:
  - Forward: idx+1, wrapping FRAME_CNT-1→0.
  - Reverse: idx-1, wrapping 0→FRAME_CNT-1.
  - `frame_idx`, base and `rom_addr` update together on the tick edge.
- A change of `play` or `dir` never alters the current frame mid-frame. Frame changes occur only on ticks.

## Timing
- Reset values:
  - `rom_addr`=0, `pic_valid`=0, `frame_idx`=0, `frame_start`=0.
  - State PAUSE, hold_cnt=0, cond_d=0, base=0.
- `rom_en` is combinational from the pixel inputs and has no reset value of its own.
- `pic_valid` = `rom_en` delayed by 1 cycle, aligned with ROM `douta`.
- The ROM samples `rom_addr` on the same edge on which `rom_addr` increments, so the first window pixel reads base+0.
- The tick and the last window pixel never coincide, because the window ends at line 395.
- Reset is asserted asynchronously and released synchronously to `vga_clk`. Reset mid-frame returns to frame 0 paused, with the address at 0.

## Structure
- Shared package `anim_pkg` holds:
  - H_VALID, V_VALID, PIC_W, PIC_H, PIC_SIZE;
  - the state enum {PAUSE, PLAY, STEP_PEND};
  - the window origin constants X0 and Y0.
- Sub-module `anim_window`: window decode (`rom_en`), `pic_valid` delay and frame-tick edge detect.
- The top level keeps the FSM, hold counter, base register and address counter.

## Test plan
- Reset, play=0, sweep one full frame → rom_addr runs 0..155999; pic_valid goes high at x=70,y=84; frame_idx stays 0.
- play=1, hold_sel=2, dir=0, 10 frames → frame_idx 0,0,1,1,2,2,3,3,0,0; base at idx 3 = 468000.
- play=1, dir=1, hold_sel=0 from idx 0 → next ticks give idx 3, 2, 1; rom_addr loads 468000, 312000, 156000.
- Paused, step pulse mid-frame → idx changes only at the next tick, by exactly +1; a second step during PLAY has no effect.
- Hold pix_x=639,pix_y=479 for 5 cycles → exactly one frame_start pulse.
- Assert rst while rom_addr=200000 (idx 1) → outputs go to 0 immediately; after release, state is PAUSE at idx 0.
